// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the instruction fetch stage: NPCOp codes, fetch states, trap causes.
package fetch_unit_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NPC_OP_W = 3;
  localparam int unsigned WAIT_W   = 8;

  // addi x0,x0,0 presented to decode whenever no fetched instruction is held
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [NPC_OP_W-1:0] NPC_PLUS4  = 3'b000;
  localparam logic [NPC_OP_W-1:0] NPC_BRANCH = 3'b001;
  localparam logic [NPC_OP_W-1:0] NPC_JUMP   = 3'b010;
  localparam logic [NPC_OP_W-1:0] NPC_JALR   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_HALT  = 2'b11
  } fetch_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } trap_cause_e;

endpackage

// File: rtl/fetch_unit_npc.sv
// Next-PC target selection; purely combinational.
module fetch_unit_npc
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0]     pc,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic [XLEN-1:0]     imm,
  input  logic [XLEN-1:0]     alu_out,
  output logic [XLEN-1:0]     target,
  output logic                misaligned
);

  // Unknown NPCOp encodings fall through to sequential flow; JALR clears bit 0.
  always_comb begin
    target = pc + XLEN'(4);
    case (npc_op)
      NPC_BRANCH, NPC_JUMP: target = pc + imm;
      NPC_JALR:             target = {alu_out[XLEN-1:1], 1'b0};
      default:              target = pc + XLEN'(4);
    endcase
    misaligned = target[1];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/rvalid, holds one instruction for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rvalid,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic                inst_valid,
  output logic [XLEN-1:0]     inst,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  input  logic                inst_ready,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic [XLEN-1:0]     imm,
  input  logic [XLEN-1:0]     alu_out,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [XLEN-1:0]     trap_addr
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Counter value seen in the last permitted waiting cycle
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

  fetch_state_e      state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [XLEN-1:0]   target;
  logic              misaligned;

  fetch_unit_npc u_npc (
    .pc        (pc),
    .npc_op    (npc_op),
    .imm       (imm),
    .alu_out   (alu_out),
    .target    (target),
    .misaligned(misaligned)
  );

  // Request and address follow the PC register directly so the address is stable while req is high.
  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);

  // Fetch sequencer: IDLE -> FETCH <-> HOLD, any trap parks in HALT until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
      trap_addr  <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        // One dead cycle so a response issued before reset is never captured
        ST_IDLE: state <= ST_FETCH;

        ST_FETCH: begin
          if (imem_rvalid) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            wait_cnt   <= '0;
            state      <= ST_HOLD;
          end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
            trap_addr  <= pc;
            state      <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        ST_HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            if (misaligned) begin
              trap       <= 1'b1;
              trap_cause <= CAUSE_MISALIGN;
              trap_addr  <= target;
              state      <= ST_HALT;
            end else begin
              pc    <= target;
              state <= ST_FETCH;
            end
          end
        end

        ST_HALT: state <= ST_HALT;

        default: state <= ST_HALT;
      endcase
    end
  end

endmodule
